// File: rtl/mips_regfile_sb.sv
// Two-read / two-write MIPS register file with optional write->read bypass,
// hardwired zero register and a per-register busy scoreboard for issue stalls.
module mips_regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy1,
   output logic              rd_busy2,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              wr_en2,
   input  logic [ADDR_W-1:0] wr_addr2,
   input  logic [DATA_W-1:0] wr_data2,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic [ADDR_W:0]   busy_cnt_q;
   logic [ADDR_W:0]   busy_cnt_d;

   logic              we1_s;
   logic              we2_s;
   logic              iss_s;
   logic [DATA_W-1:0] rd_val1_s;
   logic [DATA_W-1:0] rd_val2_s;

   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] cnt;
      cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
      end
      return cnt;
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Effective enables: anything aimed at the hardwired zero register is dropped.
   always_comb begin
      we1_s = wr_en1 && !is_zero_reg(wr_addr1);
      we2_s = wr_en2 && !is_zero_reg(wr_addr2);
      iss_s = iss_en && !is_zero_reg(iss_addr);
   end

   // Next register and scoreboard state; port 2 beats port 1, issue-set beats write-clear.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = (we2_s && (wr_addr2 == ADDR_W'(i))) ? wr_data2 :
                     (we1_s && (wr_addr1 == ADDR_W'(i))) ? wr_data1 : regs_q[i];
         busy_d[i] = (iss_s && (iss_addr == ADDR_W'(i))) ? 1'b1 :
                     ((we1_s && (wr_addr1 == ADDR_W'(i))) ||
                      (we2_s && (wr_addr2 == ADDR_W'(i)))) ? 1'b0 : busy_q[i];
      end
      busy_cnt_d = popcount(busy_d);
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         regs_q     <= '{default: '0};
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   // Read ports: optional same-cycle forwarding, zero register and reset masking.
   always_comb begin
      rd_val1_s = regs_q[rd_addr1];
      rd_val2_s = regs_q[rd_addr2];
      if ((BYPASS != 0) && we2_s && (wr_addr2 == rd_addr1)) begin
         rd_val1_s = wr_data2;
      end else if ((BYPASS != 0) && we1_s && (wr_addr1 == rd_addr1)) begin
         rd_val1_s = wr_data1;
      end else begin
         rd_val1_s = regs_q[rd_addr1];
      end
      if ((BYPASS != 0) && we2_s && (wr_addr2 == rd_addr2)) begin
         rd_val2_s = wr_data2;
      end else if ((BYPASS != 0) && we1_s && (wr_addr1 == rd_addr2)) begin
         rd_val2_s = wr_data1;
      end else begin
         rd_val2_s = regs_q[rd_addr2];
      end
      rd_data1 = (!reset_n || is_zero_reg(rd_addr1)) ? '0 : rd_val1_s;
      rd_data2 = (!reset_n || is_zero_reg(rd_addr2)) ? '0 : rd_val2_s;
      rd_busy1 = reset_n && busy_q[rd_addr1];
      rd_busy2 = reset_n && busy_q[rd_addr2];
   end

   assign busy_cnt = busy_cnt_q;

endmodule
